// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register-file geometry, opcode encodings and the
// scoreboard slot record used by the hazard tracker.
package cpu_pkg;

    localparam int NREGS = 16;              // architectural registers, r0 reads as zero
    localparam int RW    = $clog2(NREGS);   // register address width

    // Instruction opcodes (register-writing ones are sub/movl/movh/ld)
    localparam logic [3:0] OP_SUB  = 4'h0;
    localparam logic [3:0] OP_MOVL = 4'h8;
    localparam logic [3:0] OP_MOVH = 4'h9;
    localparam logic [3:0] OP_JZ   = 4'he;
    localparam logic [3:0] OP_LD   = 4'hf;

    // One in-flight register write
    typedef struct packed {
        logic          live;
        logic [RW-1:0] rt;
    } slot_t;

endpackage

// File: rtl/sb_slot_pipe.sv
// LAT-deep shift register of slot_t records that tracks in-flight writes.
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   in_slot        record entering slot[0] this edge
//   kill           squash every record currently in slots 0..LAT-2
//   retire         slot[LAT-1], the write retiring this cycle
//   pending        registers with a live write in any slot (bit 0 forced low)
//   pending_young  registers with a live write in slots 0..LAT-2 only
module sb_slot_pipe
    import cpu_pkg::*;
#(
    parameter int LAT = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  slot_t            in_slot,
    input  logic             kill,
    output slot_t            retire,
    output logic [NREGS-1:0] pending,
    output logic [NREGS-1:0] pending_young
);

    slot_t            slot_reg [LAT];
    logic [NREGS-1:0] dec      [LAT];
    logic [NREGS-1:0] pending_all;

    // Plain shift; a kill clears every record that would move into slots
    // 1..LAT-1, while the record already in slot[LAT-1] still retires.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) begin
                slot_reg[i] <= '0;
            end
        end else begin
            slot_reg[0].live <= in_slot.live & ~kill;
            slot_reg[0].rt   <= in_slot.rt;
            for (int i = 1; i < LAT; i++) begin
                slot_reg[i].live <= slot_reg[i-1].live & ~kill;
                slot_reg[i].rt   <= slot_reg[i-1].rt;
            end
        end
    end

    // One-hot decode of each live slot's destination
    genvar gi;
    generate
        for (gi = 0; gi < LAT; gi++) begin : g_dec
            assign dec[gi] = slot_reg[gi].live ? (NREGS'(1) << slot_reg[gi].rt) : '0;
        end
    endgenerate

    always_comb begin
        pending_young = '0;
        for (int i = 0; i < LAT - 1; i++) begin
            pending_young = pending_young | dec[i];
        end
        pending_all = pending_young | dec[LAT-1];
    end

    // r0 is never a hazard even if a zero destination ever slipped in
    assign pending = pending_all & ~NREGS'(1);
    assign retire  = slot_reg[LAT-1];

endmodule

// File: rtl/hazard_scoreboard.sv
// Tracks register writes in flight between decode and writeback.
// Raises a same-cycle decode stall on read-after-write hazards, squashes
// younger writes on an execute redirect and presents the retiring write.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   issue_valid/wen/rt             instruction offered by decode and its destination
//   src0_use/src0, src1_use/src1   source operands read by that instruction
//   flush                          execute redirect, kill younger in-flight writes
//   stall, issue_ack               decode hold / issue accepted this cycle
//   wb_valid, wb_rt                retiring register write
//   pending                        bitmap of registers with a live write in flight
//   stall_cnt                      saturating count of stall cycles
module hazard_scoreboard
    import cpu_pkg::*;
#(
    parameter int LAT    = 6,
    parameter int BYPASS = 0,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid,
    input  logic             issue_wen,
    input  logic [RW-1:0]    issue_rt,
    input  logic             src0_use,
    input  logic [RW-1:0]    src0,
    input  logic             src1_use,
    input  logic [RW-1:0]    src1,
    input  logic             flush,
    output logic             stall,
    output logic             issue_ack,
    output logic             wb_valid,
    output logic [RW-1:0]    wb_rt,
    output logic [NREGS-1:0] pending,
    output logic [CNT_W-1:0] stall_cnt
);

    slot_t            in_slot;
    slot_t            retire;
    logic [NREGS-1:0] pending_young;
    logic [NREGS-1:0] match_map;
    logic             hit0;
    logic             hit1;
    logic [CNT_W-1:0] stall_cnt_reg;

    sb_slot_pipe #(
        .LAT (LAT)
    ) u_pipe (
        .clk           (clk),
        .rst           (rst),
        .in_slot       (in_slot),
        .kill          (flush),
        .retire        (retire),
        .pending       (pending),
        .pending_young (pending_young)
    );

    // With a write-through regfile the retiring write is visible to the
    // reader in the same cycle, so only the younger slots can cause a stall.
    assign match_map = (BYPASS != 0) ? pending_young : pending;

    // Sources are compared against the slots only, so an instruction
    // reading its own destination never sees itself.
    assign hit0 = src0_use & (src0 != '0) & match_map[src0];
    assign hit1 = src1_use & (src1 != '0) & match_map[src1];

    assign stall     = issue_valid & (hit0 | hit1);
    assign issue_ack = issue_valid & ~stall & ~flush;

    always_comb begin
        in_slot      = '0;
        in_slot.live = issue_ack & issue_wen & (issue_rt != '0);
        in_slot.rt   = issue_rt;
    end

    assign wb_valid = retire.live;
    assign wb_rt    = retire.rt;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_reg <= '0;
        end else if (stall && (stall_cnt_reg != '1)) begin
            stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
        end
    end

    assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;
    import cpu_pkg::*;

    localparam int LAT   = 6;
    // Counter saturation is width-generic; a narrow counter keeps the
    // saturation run short.
    localparam int CNT_W = 10;

    logic             clk = 1'b0;
    logic             rst;
    logic             issue_valid, issue_wen, src0_use, src1_use, flush;
    logic [RW-1:0]    issue_rt, src0, src1;
    logic             stall, issue_ack, wb_valid;
    logic [RW-1:0]    wb_rt;
    logic [NREGS-1:0] pending;
    logic [CNT_W-1:0] stall_cnt;

    // Second instance with write-through bypass, same inputs
    logic             stall_b, issue_ack_b, wb_valid_b;
    logic [RW-1:0]    wb_rt_b;
    logic [NREGS-1:0] pending_b;
    logic [CNT_W-1:0] stall_cnt_b;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        int rt;
        int due;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    hazard_scoreboard #(.LAT(LAT), .BYPASS(0), .CNT_W(CNT_W)) u_dut (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_wen(issue_wen),
        .issue_rt(issue_rt), .src0_use(src0_use), .src0(src0), .src1_use(src1_use),
        .src1(src1), .flush(flush), .stall(stall), .issue_ack(issue_ack),
        .wb_valid(wb_valid), .wb_rt(wb_rt), .pending(pending), .stall_cnt(stall_cnt)
    );

    hazard_scoreboard #(.LAT(LAT), .BYPASS(1), .CNT_W(CNT_W)) u_dut_byp (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_wen(issue_wen),
        .issue_rt(issue_rt), .src0_use(src0_use), .src0(src0), .src1_use(src1_use),
        .src1(src1), .flush(flush), .stall(stall_b), .issue_ack(issue_ack_b),
        .wb_valid(wb_valid_b), .wb_rt(wb_rt_b), .pending(pending_b), .stall_cnt(stall_cnt_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        issue_valid = 1'b0; issue_wen = 1'b0; issue_rt = '0;
        src0_use = 1'b0; src0 = '0; src1_use = 1'b0; src1 = '0;
        flush = 1'b0;
    endtask

    // Hazard-free register write; expected to be accepted and retire LAT cycles later
    task automatic issue_w(input int rt);
        exp_t e;
        set_idle();
        issue_valid = 1'b1; issue_wen = 1'b1; issue_rt = RW'(rt);
        if (rt != 0) begin
            e.rt = rt; e.due = cyc + LAT;
            exp_q.push_back(e);
        end
        @(negedge clk);
        chk($sformatf("ack_w%0d", rt), {31'd0, issue_ack}, 32'd1);
    endtask

    // Non-writing instruction reading s0 through src0
    task automatic rd(input int s0);
        set_idle();
        issue_valid = 1'b1; src0_use = 1'b1; src0 = RW'(s0);
    endtask

    // Expectation model: flush/reset in this cycle removes everything not
    // already sitting in the retiring slot.
    task automatic model_kill();
        while (exp_q.size() > 0 && exp_q[$].due > cyc) void'(exp_q.pop_back());
    endtask

    task automatic drain();
        set_idle();
        repeat (LAT + 1) tick();
    endtask

    // Writeback monitor
    always @(negedge clk) begin
        exp_t e;
        while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
            e = exp_q.pop_front();
            chk($sformatf("wb_missing_rt%0d", e.rt), 32'd0, 32'd1);
        end
        if (!rst && wb_valid) begin
            if (exp_q.size() == 0) begin
                chk("wb_unexpected_rt", {28'd0, wb_rt}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("wb_rt", {28'd0, wb_rt}, e.rt);
                chk("wb_time", cyc, e.due);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        set_idle();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        issue_valid = 1'b1;
        @(negedge clk);
        chk("rst_pending", pending, 0);
        chk("rst_wb_valid", {31'd0, wb_valid}, 0);
        chk("rst_stall", {31'd0, stall}, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_ack", {31'd0, issue_ack}, 1);

        // 1: single write, pending window and writeback timing
        tick(); issue_w(3);
        tick(); set_idle();
        @(negedge clk); chk("t1_pending", pending, 32'h0008);
        repeat (5) tick();
        @(negedge clk); chk("t1_pending_wb", pending, 32'h0008);
        tick();
        @(negedge clk); chk("t1_pending_after", pending, 0);

        // 2: RAW stall duration, plain and bypassed
        tick(); issue_w(5);
        tick(); rd(5);
        n = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (!stall) break;
            n++;
            tick();
        end
        chk("t2_stall_cycles", n, 6);
        chk("t2_ack", {31'd0, issue_ack}, 1);
        chk("t2_stall_cnt", stall_cnt, 6);
        chk("t2_stall_cnt_byp", stall_cnt_b, 5);
        tick(); set_idle();
        drain();

        // 3: r0 never a hazard, use bits gate hits, rt=0 never retires
        tick(); issue_w(7);
        tick(); set_idle();
        issue_valid = 1'b1; issue_wen = 1'b1; issue_rt = '0;
        src0_use = 1'b1; src0 = '0; src1_use = 1'b1; src1 = '0;
        @(negedge clk);
        chk("t3_r0_stall", {31'd0, stall}, 0);
        chk("t3_r0_ack", {31'd0, issue_ack}, 1);
        tick(); set_idle();
        issue_valid = 1'b1; src1_use = 1'b1; src1 = 4'd7;
        @(negedge clk);
        chk("t3_src1_stall", {31'd0, stall}, 1);
        chk("t3_src1_ack", {31'd0, issue_ack}, 0);
        tick(); set_idle();
        issue_valid = 1'b1; src0_use = 1'b0; src0 = 4'd7;
        @(negedge clk);
        chk("t3_nouse_stall", {31'd0, stall}, 0);
        drain();

        // 4: flush with rt=1 retiring, 2 and 3 killed
        tick(); issue_w(1);
        tick(); issue_w(2);
        tick(); issue_w(3);
        tick(); set_idle();
        repeat (3) tick();
        flush = 1'b1;
        model_kill();
        @(negedge clk); chk("t4_pending_flush", pending, 32'h000E);
        tick(); flush = 1'b0;
        @(negedge clk);
        chk("t4_pending_after", pending, 0);
        chk("t4_wb_after", {31'd0, wb_valid}, 0);
        drain();

        // 5: flush concurrent with issue
        tick(); issue_w(4);
        tick(); rd(4); flush = 1'b1;
        model_kill();
        @(negedge clk);
        chk("t5_flush_stall", {31'd0, stall}, 1);
        chk("t5_flush_stall_ack", {31'd0, issue_ack}, 0);
        tick(); set_idle();
        issue_valid = 1'b1; issue_wen = 1'b1; issue_rt = 4'd9; flush = 1'b1;
        @(negedge clk);
        chk("t5_flush_ack", {31'd0, issue_ack}, 0);
        chk("t5_flush_nostall", {31'd0, stall}, 0);
        tick(); set_idle();
        @(negedge clk); chk("t5_pending", pending, 0);
        drain();

        // 6: saturation, then reset mid-stream
        tick(); rst = 1'b1;
        tick(); rst = 1'b0;
        @(negedge clk); chk("t6_cnt_clear", stall_cnt, 0);
        for (int r = 0; r < 180; r++) begin
            tick(); issue_w(6);
            if (r == 10) chk("t6_cnt_60", stall_cnt, 60);
            for (int j = 0; j < 6; j++) begin
                tick(); rd(6);
            end
        end
        tick(); set_idle();
        @(negedge clk); chk("t6_cnt_sat", stall_cnt, (1 << CNT_W) - 1);
        tick(); issue_w(6);
        tick(); set_idle();
        @(negedge clk); chk("t6_pending_pre", pending, 32'h0040);
        tick(); rst = 1'b1;
        model_kill();
        tick(); rst = 1'b0;
        @(negedge clk);
        chk("t6_rst_pending", pending, 0);
        chk("t6_rst_cnt", stall_cnt, 0);
        chk("t6_rst_wb", {31'd0, wb_valid}, 0);
        drain();
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
